// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types, widths and encodings for the UART receive frame controller
//
// Purpose: frame-state encoding, counter width helpers and parity-type codes
//          shared by the interface, the edge/bit counter and the top module.
// Ports:   none (package).

package uart_rx_pkg;

  localparam int DEF_PRESCALE   = 8;
  localparam int DEF_DATA_WIDTH = 8;

  // Counter widths for the default build; parameterised instances derive
  // their own widths through the helper functions below.
  localparam int EDGE_CNT_W = $clog2(DEF_PRESCALE);
  localparam int BIT_CNT_W  = $clog2(DEF_DATA_WIDTH + 1);

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  function automatic int edge_cnt_w(input int prescale);
    return $clog2(prescale);
  endfunction

  function automatic int bit_cnt_w(input int data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// rtl/uart_rx_frame_ctrl_if.sv - sampler, configuration and result signals of the UART receiver
//
// Purpose: bundles everything between the frame controller and its
//          surroundings except clk/rst.
// Ports (slave = controller side):
//   in : start_bit_detector_i, sampled_bit_i, parity_en_i, parity_type_i
//   out: sampler_enable_o, sample_one_bit_o, sample_three_bit_o, rx_data_o,
//        rx_valid_o, parity_error_o, stop_error_o, busy_o

interface uart_rx_frame_ctrl_if
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  start_bit_detector_i;
  logic                  sampled_bit_i;
  logic                  parity_en_i;
  logic                  parity_type_i;
  logic                  sampler_enable_o;
  logic                  sample_one_bit_o;
  logic                  sample_three_bit_o;
  logic [DATA_WIDTH-1:0] rx_data_o;
  logic                  rx_valid_o;
  logic                  parity_error_o;
  logic                  stop_error_o;
  logic                  busy_o;

  modport slave (
    input  start_bit_detector_i, sampled_bit_i, parity_en_i, parity_type_i,
    output sampler_enable_o, sample_one_bit_o, sample_three_bit_o, rx_data_o,
           rx_valid_o, parity_error_o, stop_error_o, busy_o
  );

  modport master (
    output start_bit_detector_i, sampled_bit_i, parity_en_i, parity_type_i,
    input  sampler_enable_o, sample_one_bit_o, sample_three_bit_o, rx_data_o,
           rx_valid_o, parity_error_o, stop_error_o, busy_o
  );

endinterface

// File: rtl/uart_rx_edge_bit_counter.sv
// rtl/uart_rx_edge_bit_counter.sv - oversampling edge counter, data bit counter and bit-centre strobe
//
// Purpose: times each serial bit in clk cycles and counts received data bits.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   load_i        : frame start; edge_cnt <= 1, bit_cnt <= 0
//   active_i      : controller is inside a frame (state != IDLE)
//   data_state_i  : controller is in the DATA state
//   wrap_o        : last cycle of the current bit period
//   strobe_o      : bit-centre cycle
//   last_bit_o    : current data bit is the final one

module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE   = DEF_PRESCALE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic active_i,
  input  logic data_state_i,
  output logic wrap_o,
  output logic strobe_o,
  output logic last_bit_o
);

  localparam int EW = edge_cnt_w(PRESCALE);
  localparam int BW = bit_cnt_w(DATA_WIDTH);

  localparam logic [EW-1:0] EDGE_MAX = EW'(PRESCALE - 1);
  localparam logic [EW-1:0] EDGE_MID = EW'(PRESCALE / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  logic [EW-1:0] edge_cnt_q, edge_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;

  assign wrap_o     = active_i && (edge_cnt_q == EDGE_MAX);
  assign strobe_o   = active_i && (edge_cnt_q == EDGE_MID);
  assign last_bit_o = (bit_cnt_q == BIT_LAST);

  // The detect cycle itself is edge 0 of the start bit, so the first
  // in-frame cycle already counts as edge 1.
  always_comb begin
    edge_cnt_d = '0;
    bit_cnt_d  = '0;
    if (load_i) begin
      edge_cnt_d = EW'(1);
    end else if (active_i) begin
      edge_cnt_d = wrap_o ? '0 : edge_cnt_q + EW'(1);
      bit_cnt_d  = bit_cnt_q + BW'(data_state_i && wrap_o);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - UART receive frame controller and deserializer
//
// Purpose: detects a start bit, strobes the sampler at each bit centre,
//          shifts data in LSB first, checks parity and stop bit, and emits a
//          one-cycle valid or error pulse per frame.
// Ports:
//   clk, rst : oversampling clock (PRESCALE cycles per bit), sync active-high reset
//   bus      : uart_rx_frame_ctrl_if.slave (sampler handshake, config, results)

module uart_rx_frame_ctrl
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE   = DEF_PRESCALE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_rx_frame_ctrl_if.slave    bus
);

  rx_state_e             state_q, state_d;
  logic                  sampler_enable_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q, par_type_q, par_err_q;
  logic                  rx_valid_q, parity_error_q, stop_error_q;
  logic                  start_go, wrap, strobe, last_bit, par_exp;

  // No frame may start until the sampler has been running for a cycle.
  assign start_go = (state_q == ST_IDLE) && bus.start_bit_detector_i && sampler_enable_q;

  uart_rx_edge_bit_counter #(
    .PRESCALE   (PRESCALE),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cnt (
    .clk          (clk),
    .rst          (rst),
    .load_i       (start_go),
    .active_i     (state_q != ST_IDLE),
    .data_state_i (state_q == ST_DATA),
    .wrap_o       (wrap),
    .strobe_o     (strobe),
    .last_bit_o   (last_bit)
  );

  always_comb begin
    par_exp = ^data_q;
    case (par_type_q)
      PARITY_EVEN: par_exp = ^data_q;
      PARITY_ODD:  par_exp = ~^data_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_go) state_d = ST_START;
      ST_START: begin
        if (strobe && bus.sampled_bit_i) state_d = ST_IDLE;  // start glitch
        else if (wrap)                   state_d = ST_DATA;
      end
      ST_DATA:   if (wrap && last_bit) state_d = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY: if (wrap) state_d = ST_STOP;
      // Leave at the stop-bit centre so a back-to-back start bit is not missed.
      ST_STOP:   if (strobe) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      sampler_enable_q <= 1'b0;
      data_q           <= '0;
      par_en_q         <= 1'b0;
      par_type_q       <= 1'b0;
      par_err_q        <= 1'b0;
      rx_valid_q       <= 1'b0;
      parity_error_q   <= 1'b0;
      stop_error_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      sampler_enable_q <= 1'b1;
      rx_valid_q       <= 1'b0;
      parity_error_q   <= 1'b0;
      stop_error_q     <= 1'b0;
      if (start_go) begin
        par_en_q   <= bus.parity_en_i;
        par_type_q <= bus.parity_type_i;
        par_err_q  <= 1'b0;
      end
      if (strobe) begin
        case (state_q)
          ST_DATA:   data_q <= {bus.sampled_bit_i, data_q[DATA_WIDTH-1:1]};
          ST_PARITY: if (bus.sampled_bit_i != par_exp) par_err_q <= 1'b1;
          ST_STOP: begin
            // A bad stop bit outranks a parity mismatch.
            stop_error_q   <= ~bus.sampled_bit_i;
            parity_error_q <= bus.sampled_bit_i & par_err_q;
            rx_valid_q     <= bus.sampled_bit_i & ~par_err_q;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.sampler_enable_o   = sampler_enable_q;
  assign bus.sample_one_bit_o   = 1'b0;
  assign bus.sample_three_bit_o = strobe;
  assign bus.rx_data_o          = data_q;
  assign bus.rx_valid_o         = rx_valid_q;
  assign bus.parity_error_o     = parity_error_q;
  assign bus.stop_error_o       = stop_error_q;
  assign bus.busy_o             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb/tb_uart_rx_frame_ctrl.sv - self-checking bench for uart_rx_frame_ctrl with a 3-sample voting sampler model

module tb_uart_rx_frame_ctrl;

  localparam int P  = 8;
  localparam int DW = 8;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic line = 1'b1;
  int   cyc  = 0;
  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  logic [2:0] sh;

  typedef struct {
    logic [2:0] pulses;  // {stop_error, parity_error, rx_valid}
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic [2:0] mon_pulses;

  uart_rx_frame_ctrl_if #(.DATA_WIDTH(DW)) bus();

  uart_rx_frame_ctrl #(.PRESCALE(P), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sampler model: 3-deep shift of the line, majority vote.
  always @(posedge clk) begin
    if (rst) sh <= 3'b111;
    else if (bus.sampler_enable_o) sh <= {sh[1:0], line};
  end
  assign bus.start_bit_detector_i = ~line;
  assign bus.sampled_bit_i = (sh[0] & sh[1]) | (sh[0] & sh[2]) | (sh[1] & sh[2]);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard side: every outcome pulse must match the oldest expectation.
  always @(negedge clk) begin
    mon_pulses = {bus.stop_error_o, bus.parity_error_o, bus.rx_valid_o};
    if (!rst && mon_pulses != 3'b000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(mon_pulses), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_kind", 32'(mon_pulses), 32'(mon_e.pulses));
        check("pulse_cycle", cyc, mon_e.cyc);
        if (mon_e.pulses == 3'b001) check("rx_data", 32'(bus.rx_data_o), 32'(mon_e.data));
      end
    end
  end

  task automatic idle(input int n);
    line = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; abort_t >= 0 pulses rst at that bit-time offset instead.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptype,
                            input logic pbit, input logic stop, input int abort_t);
    logic [10:0] bits;
    int   nbits;
    int   start;
    exp_t e;
    logic par_bit_ok;
    bits = '0;
    for (int i = 0; i < DW; i++) bits[i+1] = d[i];
    nbits = DW + 2 + int'(pen);
    if (pen) bits[DW+1] = pbit;
    bits[nbits-1] = stop;
    bus.parity_en_i   = pen;
    bus.parity_type_i = ptype;
    start = cyc + 1;
    if (abort_t < 0) begin
      par_bit_ok = ((^d) ^ ptype) == pbit;
      e.data   = d;
      e.cyc    = start + P/2 + P*(DW + 1 + int'(pen));
      e.pulses = !stop ? 3'b100 : (pen && !par_bit_ok) ? 3'b010 : 3'b001;
      exp_q.push_back(e);
    end
    for (int t = 0; t < nbits*P; t++) begin
      line = bits[t / P];
      // A low stop bit is released just after its centre so it is not read as a new start.
      if (!stop && t > (nbits-1)*P + P/2) line = 1'b1;
      if (t == 2*P) begin
        bus.parity_en_i   = ~pen;
        bus.parity_type_i = ~ptype;
      end
      if (t == abort_t) rst = 1'b1;
      @(posedge clk);
      #1;
      if (t == P/2 - 1) check("strobe_centre", 32'(bus.sample_three_bit_o), 32'd1);
      if (t == P/2)     check("strobe_off", 32'(bus.sample_three_bit_o), 32'd0);
      if (t == abort_t) begin
        rst  = 1'b0;
        line = 1'b1;
        check("abort_busy", 32'(bus.busy_o), 32'd0);
        check("abort_sampler_en", 32'(bus.sampler_enable_o), 32'd0);
        check("abort_rx_data", 32'(bus.rx_data_o), 32'd0);
        check("abort_pulses", 32'({bus.stop_error_o, bus.parity_error_o, bus.rx_valid_o}), 32'd0);
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.parity_en_i   = 1'b0;
    bus.parity_type_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sampler_en", 32'(bus.sampler_enable_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_rx_data", 32'(bus.rx_data_o), 32'd0);
    check("rst_pulses", 32'({bus.stop_error_o, bus.parity_error_o, bus.rx_valid_o}), 32'd0);
    check("rst_strobe3", 32'(bus.sample_three_bit_o), 32'd0);
    check("rst_strobe1", 32'(bus.sample_one_bit_o), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("sampler_en_after_rst", 32'(bus.sampler_enable_o), 32'd1);
    idle(4);

    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1);  // no parity, valid
    idle(5);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, -1);  // even parity ok
    idle(5);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, -1);  // even parity wrong
    idle(5);
    send_frame(8'h00, 1'b1, 1'b1, 1'b1, 1'b1, -1);  // odd parity ok
    idle(5);
    send_frame(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, -1);  // bad stop and bad parity
    idle(5);

    // Start glitch: line low for two cycles only.
    bus.parity_en_i = 1'b0;
    for (int t = 0; t < 12; t++) begin
      line = (t < 2) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      if (t == 3) check("glitch_busy_c3", 32'(bus.busy_o), 32'd1);
      if (t == 4) check("glitch_busy_c4", 32'(bus.busy_o), 32'd0);
    end
    idle(5);

    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, -1);  // back-to-back pair
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle(5);

    send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 30);  // reset mid-DATA
    idle(16);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle(20);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
